// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter (and the matching receiver).
package uart_tx_pkg;

    // Payload bits per frame unless a block overrides it.
    localparam int DATA_WIDTH_DEFAULT = 8;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_parity.sv
// Parity bit generator: even parity when parTyp_i=0, odd parity when parTyp_i=1.
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  parTyp_i,
    output logic                  parity_o
);

    // Reduction XOR gives the even-parity bit; odd parity is its inverse.
    always_comb begin
        parity_o = (^data_i) ^ parTyp_i;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one bit per clock, start / data (LSB first) / optional parity / stop.
// TX_OUT and busy are registered and always reflect the state currently being sent.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  parEn_q, parEn_d;
    logic                  parTyp_q, parTyp_d;
    logic                  txOut_q, txOut_d;
    logic                  busy_q, busy_d;
    logic                  parityBit;

    uart_tx_parity #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data_i   (data_q),
        .parTyp_i (parTyp_q),
        .parity_o (parityBit)
    );

    // State register plus frame latch and registered line outputs; reset abandons any frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            data_q   <= '0;
            parEn_q  <= 1'b0;
            parTyp_q <= 1'b0;
            txOut_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            data_q   <= data_d;
            parEn_q  <= parEn_d;
            parTyp_q <= parTyp_d;
            txOut_q  <= txOut_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: inputs are only sampled in IDLE, so mid-frame changes cannot leak in.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        data_d   = data_q;
        parEn_d  = parEn_q;
        parTyp_d = parTyp_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d  = START;
                    data_d   = P_DATA;
                    parEn_d  = PAR_EN;
                    parTyp_d = PAR_TYP;
                end
            end
            START: begin
                state_d  = DATA;
                bitCnt_d = '0;
            end
            DATA: begin
                if (bitCnt_q == LAST_BIT) begin
                    state_d = parEn_q ? PARITY : STOP;
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux keyed on the state being entered, so the registers line up with state_q.
    always_comb begin
        txOut_d = 1'b1;
        busy_d  = 1'b1;
        case (state_d)
            IDLE: begin
                txOut_d = 1'b1;
                busy_d  = 1'b0;
            end
            START: begin
                txOut_d = 1'b0;
            end
            DATA: begin
                txOut_d = data_q[bitCnt_d];
            end
            PARITY: begin
                txOut_d = parityBit;
            end
            STOP: begin
                txOut_d = 1'b1;
            end
            default: begin
                txOut_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = txOut_q;
    assign busy   = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001: The block SHALL have parameter DATA_WIDTH, default 8, which sets the number of payload bits per frame.
REQ-002: The block SHALL have port CLK, input, 1 bit: the single clock, at one rising edge per transmitted bit.
REQ-003: The block SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-004: The block SHALL have port P_DATA, input, DATA_WIDTH bits: the parallel byte to send, normally the FIFO read data.
REQ-005: The block SHALL have port Data_Valid, input, 1 bit: a transmit request, normally the inverse of FIFO empty.
REQ-006: The block SHALL have port PAR_EN, input, 1 bit: 1 means a parity bit is inserted.
REQ-007: The block SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity and 1 selects odd parity.
REQ-008: The block SHALL have port TX_OUT, output, 1 bit: the serial line, with idle level 1.
REQ-009: The block SHALL have port busy, output, 1 bit: high for the whole frame, and its rising edge is the FIFO pop strobe.

Function
REQ-010: The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and all outputs SHALL be registered.
REQ-011: In IDLE, TX_OUT SHALL be 1 and busy SHALL be 0.
REQ-012: The frame SHALL be accepted at the first edge where the state is IDLE and Data_Valid=1.
REQ-013: At that edge the block SHALL latch P_DATA, PAR_EN and PAR_TYP, and SHALL move to START.
REQ-014: In START, TX_OUT SHALL be 0 and busy SHALL be 1 for 1 cycle, so the start bit appears 1 cycle after acceptance.
REQ-015: DATA SHALL last DATA_WIDTH cycles and send the latched data LSB first, using a bit counter 0..DATA_WIDTH-1.
REQ-016: After the last data bit, the next state SHALL be PARITY if the latched PAR_EN=1, otherwise STOP.
REQ-017: PARITY SHALL last 1 cycle, and TX_OUT SHALL equal the XOR of the latched data, inverted when the latched PAR_TYP=1.
REQ-018: STOP SHALL last 1 cycle with TX_OUT=1 and busy=1, and SHALL always be followed by IDLE.
REQ-019: busy SHALL be high for exactly DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity.
REQ-020: There SHALL be at least 1 IDLE cycle with busy=0 between frames, so every frame produces exactly one busy rising edge.
REQ-021: Data_Valid, P_DATA, PAR_EN and PAR_TYP SHALL be ignored outside IDLE, and changing them mid-frame SHALL NOT affect the frame in flight.
REQ-022: If Data_Valid is held high continuously, frames SHALL follow back-to-back, separated by 1 IDLE cycle each.
REQ-023: The bit counter SHALL clear on entry to DATA and SHALL NOT wrap into a further data bit.

Reset
REQ-024: When RST=0 at an edge, the block SHALL set state=IDLE, TX_OUT=1, busy=0, the bit counter to 0 and the latched data to 0.
REQ-025: Reset SHALL apply in any state; a partial frame is abandoned and the line returns to 1 at that edge.
REQ-026: The first edge with RST=1 SHALL be able to accept a new request, with no retransmission of an aborted frame.

Structure
REQ-027: Shared package uart_tx_pkg SHALL hold the FSM state typedef (IDLE..STOP) and the DATA_WIDTH default constant, for reuse by the RX side.
REQ-028: Parity generation SHALL be one sub-module, uart_tx_parity (inputs: data, type; output: parity bit), which is purely combinational on the latched data.
REQ-029: The FSM, bit counter, data latch and output mux SHALL stay in uart_tx.

Verification
REQ-030: Scenario — P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; busy high 10 cycles, then 0.
REQ-031: Scenario — P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; with PAR_TYP=1 -> parity bit 1; busy high 11 cycles.
REQ-032: Scenario — P_DATA=0x01, PAR_EN=1, PAR_TYP=0 -> data bits 1,0,0,0,0,0,0,0, parity bit 1, stop bit 1.
REQ-033: Scenario — Data_Valid held high, P_DATA changed 0x3C->0xFF mid-frame -> the first frame sends 0x3C unchanged, then 1 idle cycle with busy=0, then a 0xFF frame; exactly 2 busy rising edges.
REQ-034: Scenario — RST=0 during data bit 3 of 0x55 -> at that edge TX_OUT=1 and busy=0; RST=1 with Data_Valid=1 -> a fresh complete frame, start bit 1 cycle later.
REQ-035: Scenario — PAR_EN toggled from 0 to 1 mid-frame -> no parity bit in that frame; the next frame includes parity.
